spi_pixel_rx: RTL and testbench
===============================

# spi_pixel_rx

SPI slave receiver that turns the MCU's SPI pixel stream into frame-buffer write requests. It sits between the `sck`/`sdi`/`cs` pins and the frame-buffer write port inside `top`. The block synchronizes the SPI signals into `clk_hf`, deserializes bytes, decodes an address-then-pixels frame, and issues one valid/ready write per pixel with an auto-incrementing address.

## Interface
- `ADDR_W`, 15: frame-buffer word address width (160x120 = 19200 words).
- `DATA_W`, 12: pixel width, RGB444 packed as {r[3:0], g[3:0], b[3:0]}.
- `clk_hf`  in  1  system clock, 48 MHz HSOSC; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `sck`  in  1  SPI clock from MCU, mode 0, asynchronous to `clk_hf`.
- `sdi`  in  1  SPI data, MSB first.
- `cs`  in  1  chip select, active low.
- `wr_valid`  out  1  write request pending.
- `wr_addr`  out  ADDR_W  frame-buffer address.
- `wr_data`  out  DATA_W  pixel value.
- `wr_ready`  in  1  frame buffer accepts the write this cycle.
- `overflow`  out  1  sticky dropped-pixel flag; present only with `SPI_RX_OVF_EN`.

## Operation
- `sck`, `sdi`, `cs` each pass through a 2-flop synchronizer. A third `sck` flop provides edge detection. A sync-domain `sck` rising edge while sync `cs` = 0 shifts sync `sdi` into an 8-bit shift register. Bit counter 0..7.
- Frame = `cs` falling … `cs` rising. Byte order: ADDR_HI, ADDR_LO, then repeated PIX_HI, PIX_LO pairs.
- FSM states: IDLE, ADDR_HI, ADDR_LO, PIX_HI, PIX_LO.
  - IDLE → ADDR_HI on sync `cs` falling.
  - ADDR_HI → ADDR_LO on byte done; latch `addr[ADDR_W-1:8]` from byte[ADDR_W-9:0], and ignore the upper bits.
  - ADDR_LO → PIX_HI on byte done; latch `addr[7:0]`.
  - PIX_HI → PIX_LO on byte done; hold the byte.
  - PIX_LO → PIX_HI on byte done; form word {hi, lo}[DATA_W-1:0], issue a write at the current addr, then addr += 1.
  - Any state → IDLE on sync `cs` high. Partial byte, partial address, and unpaired PIX_HI are discarded, with no write.
- Address increments modulo 2^ADDR_W: 0x7FFF wraps to 0x0000.
- Output register is single-entry. `wr_addr`/`wr_data` are loaded with `wr_valid`, held stable until `wr_valid && wr_ready`, then `wr_valid` clears.
- A pixel that completes while `wr_valid && !wr_ready` is dropped. The register keeps the older pixel, and addr still increments.
- A pixel that completes in the same cycle as an accept (`wr_valid && wr_ready`) loads the new pixel, and `wr_valid` stays 1. This is not a drop.
- A pending write survives `cs` deassertion and is still delivered.

## Timing
- Reset values: `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `overflow` 0. FSM IDLE, counters 0, all synchronizer flops reset to the idle levels (`sck` 0, `cs` 1).
- Reset mid-frame: immediate return to IDLE and the pending write is lost. After reset release, a new `cs` falling edge is required; a `cs` already low at release is ignored until it rises.
- Latency: `wr_valid` rises on the 4th `clk_hf` rising edge after the pin-level `sck` rising edge carrying the pixel's last bit (2 sync + 1 edge detect + 1 output load).
- `sck` ≤ `clk_hf`/8 (6 MHz). `sck` high and low phases must each be ≥ 3 `clk_hf` periods, and `sdi` must be stable across the `sck` rising edge by ≥ 3 `clk_hf` periods.
- `cs` high time between frames ≥ 3 `clk_hf` periods.

## Configuration
- `SPI_RX_OVF_EN` defined:
  - `overflow` port exists.
  - Set on any dropped pixel and stays set.
  - Cleared only by `reset` or on sync `cs` falling edge.
- `SPI_RX_OVF_EN` undefined:
  - Port and logic are absent.
  - Drops still occur silently with identical write behaviour.

## Structure
- Package `spi_rx_pkg`:
  - FSM state enum `spi_rx_state_t`.
  - `SYNC_STAGES` = 2.
  - Byte width constant `SPI_BYTE_W` = 8.
- Sub-module `sync_ff`: parameterized-reset-value 2-flop synchronizer, instantiated three times.
- Everything else is inline in `spi_pixel_rx`.

## Test plan
- Frame 0x00,0x10,0x0A,0xBC,0x01,0x23 with `wr_ready` = 1 → two writes: (0x0010, 0xABC), then (0x0011, 0x123). `wr_valid` is one cycle high each.
- Frame at address 0x7FFF with two pixels → writes to 0x7FFF, then 0x0000.
- `wr_ready` = 0 throughout a 3-pixel frame:
  - Only the first pixel is held.
  - `overflow` = 1 after the second pixel (with macro).
  - Raising `wr_ready` delivers exactly one write.
- `cs` rises after 5 bits of PIX_LO → no write. The next frame decodes its address correctly from a fresh ADDR_HI.
- Reset asserted while `wr_valid` = 1 and mid-byte → all outputs 0 immediately. A subsequent full frame writes correctly.
- Accept and new pixel completion in the same cycle (`wr_ready` pulsed at that cycle) → both pixels written in order, `overflow` stays 0.

Source files
------------

// File: rtl/spi_pixel_rx_pkg.sv
// Shared types and constants for the SPI pixel receiver.
package spi_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_PIX_HI,
    ST_PIX_LO
  } spi_rx_state_t;

  localparam int SYNC_STAGES = 2;
  localparam int SPI_BYTE_W  = 8;

endpackage

// File: rtl/spi_pixel_rx_if.sv
// Frame-buffer write port: single-entry valid/ready request with address and pixel.
interface spi_pixel_rx_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
);
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/spi_pixel_rx_sync_ff.sv
// Multi-flop synchronizer with a configurable reset level (idle level of the pin).
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ff_reg <= {STAGES{RST_VAL}};
    else     ff_reg <= {ff_reg[STAGES-2:0], d};
  end

  assign q = ff_reg[STAGES-1];
endmodule

// File: rtl/spi_pixel_rx.sv
// SPI mode-0 slave that decodes ADDR_HI, ADDR_LO, {PIX_HI, PIX_LO}* frames into frame-buffer writes.
// Optional sticky dropped-pixel flag is built when SPI_RX_OVF_EN is defined.
module spi_pixel_rx
  import spi_rx_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 12
) (
  input  logic clk_hf,
  input  logic reset,
  input  logic sck,
  input  logic sdi,
  input  logic cs,
  spi_pixel_rx_if.master wr
`ifdef SPI_RX_OVF_EN
  ,
  output logic overflow
`endif
);
  logic sck_s, sdi_s, cs_s;
  logic sck_q, cs_q;
  logic [1:0] flush_cnt;
  logic armed;
  logic sck_rise, cs_fall;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (.clk(clk_hf), .rst(reset), .d(sck), .q(sck_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (.clk(clk_hf), .rst(reset), .d(sdi), .q(sdi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs  (.clk(clk_hf), .rst(reset), .d(cs),  .q(cs_s));

  // cs edges are only trusted once the synchronizer holds real pin data and cs has been seen high,
  // so a cs already low when reset releases cannot start a frame.
  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      sck_q     <= 1'b0;
      cs_q      <= 1'b1;
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else begin
      sck_q <= sck_s;
      cs_q  <= cs_s;
      if (flush_cnt != 2'(SYNC_STAGES)) flush_cnt <= flush_cnt + 2'd1;
      else if (cs_s)                    armed     <= 1'b1;
    end
  end

  assign sck_rise = sck_s & ~sck_q;
  assign cs_fall  = armed & cs_q & ~cs_s;

  spi_rx_state_t state_reg, state_next;

  logic [SPI_BYTE_W-2:0] shift_reg;
  logic [2:0]            bit_cnt_reg;
  logic                  byte_done_reg;
  logic [SPI_BYTE_W-1:0] byte_reg;

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      byte_done_reg <= 1'b0;
      byte_reg      <= '0;
    end else if (cs_s || state_reg == ST_IDLE) begin
      bit_cnt_reg   <= '0;
      byte_done_reg <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      if (sck_rise) begin
        shift_reg   <= {shift_reg[SPI_BYTE_W-3:0], sdi_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'(SPI_BYTE_W - 1)) begin
          byte_done_reg <= 1'b1;
          byte_reg      <= {shift_reg, sdi_s};
        end
      end
    end
  end

  logic [ADDR_W-1:0]     addr_reg, addr_next;
  logic [SPI_BYTE_W-1:0] pix_hi_reg, pix_hi_next;
  logic                  pix_done;
  logic [DATA_W-1:0]     pix_word;

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      addr_reg   <= '0;
      pix_hi_reg <= '0;
    end else begin
      state_reg  <= state_next;
      addr_reg   <= addr_next;
      pix_hi_reg <= pix_hi_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    pix_hi_next = pix_hi_reg;
    pix_done    = 1'b0;
    if (cs_s) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE:    if (cs_fall) state_next = ST_ADDR_HI;
        ST_ADDR_HI: if (byte_done_reg) begin
          addr_next[ADDR_W-1:8] = byte_reg[ADDR_W-9:0];
          state_next            = ST_ADDR_LO;
        end
        ST_ADDR_LO: if (byte_done_reg) begin
          addr_next[7:0] = byte_reg;
          state_next     = ST_PIX_HI;
        end
        ST_PIX_HI:  if (byte_done_reg) begin
          pix_hi_next = byte_reg;
          state_next  = ST_PIX_LO;
        end
        ST_PIX_LO:  if (byte_done_reg) begin
          pix_done   = 1'b1;
          addr_next  = addr_reg + ADDR_W'(1);
          state_next = ST_PIX_HI;
        end
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  assign pix_word = DATA_W'({pix_hi_reg, byte_reg});

  logic              valid_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              drop;

  // An accept in the same cycle frees the slot, so only a still-blocked register drops.
  assign drop = pix_done & valid_reg & ~wr.wr_ready;

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset) begin
      valid_reg    <= 1'b0;
      out_addr_reg <= '0;
      out_data_reg <= '0;
    end else if (pix_done && !drop) begin
      valid_reg    <= 1'b1;
      out_addr_reg <= addr_reg;
      out_data_reg <= pix_word;
    end else if (valid_reg && wr.wr_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign wr.wr_valid = valid_reg;
  assign wr.wr_addr  = out_addr_reg;
  assign wr.wr_data  = out_data_reg;

`ifdef SPI_RX_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk_hf or posedge reset) begin
    if (reset)        ovf_reg <= 1'b0;
    else if (drop)    ovf_reg <= 1'b1;
    else if (cs_fall) ovf_reg <= 1'b0;
  end

  assign overflow = ovf_reg;
`endif

endmodule

// File: tb/tb_spi_pixel_rx.sv
// Scoreboard bench for spi_pixel_rx: directed SPI frames, expected writes queued, monitor checks accepts.
module tb_spi_pixel_rx;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 12;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sck = 1'b0;
  logic sdi = 1'b0;
  logic cs = 1'b1;
`ifdef SPI_RX_OVF_EN
  logic overflow;
`endif

  spi_pixel_rx_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  spi_pixel_rx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_hf(clk),
    .reset(reset),
    .sck(sck),
    .sdi(sdi),
    .cs(cs),
    .wr(bus)
`ifdef SPI_RX_OVF_EN
    ,
    .overflow(overflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_acc    = 0;
  int n_vcyc   = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [7:0] fb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  // Monitor: every accepted write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_valid) n_vcyc++;
      if (bus.wr_valid && bus.wr_ready) begin
        logic [ADDR_W+DATA_W-1:0] e;
        n_acc++;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected none",
                   bus.wr_addr, bus.wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.wr_addr, bus.wr_data} === e) begin
            n_pass++;
            $display("write addr 0x%04h data 0x%03h ok", bus.wr_addr, bus.wr_data);
          end else begin
            $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                     bus.wr_addr, bus.wr_data, e[ADDR_W+DATA_W-1:DATA_W], e[DATA_W-1:0]);
          end
        end
      end
    end
  end

  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      sdi = b[7-i];
      clk_wait(4);
      sck = 1'b1;
      clk_wait(4);
      sck = 1'b0;
    end
  endtask

  task automatic cs_start();
    @(negedge clk);
    cs = 1'b0;
    clk_wait(4);
  endtask

  task automatic cs_end();
    clk_wait(4);
    cs = 1'b1;
    clk_wait(8);
  endtask

  task automatic send_bytes();
    for (int i = 0; i < fb.size(); i++) spi_bits(fb[i], 8);
  endtask

  task automatic send_frame();
    cs_start();
    send_bytes();
    cs_end();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int acc0, vc0;
    bus.wr_ready = 1'b1;
    clk_wait(3);
    check("reset_wr_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("reset_wr_addr", {17'd0, bus.wr_addr}, 32'd0);
    check("reset_wr_data", {20'd0, bus.wr_data}, 32'd0);
`ifdef SPI_RX_OVF_EN
    check("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    clk_wait(6);

    // Basic two-pixel frame, ready always high.
    acc0 = n_acc; vc0 = n_vcyc;
    push_exp(15'h0010, 12'hABC);
    push_exp(15'h0011, 12'h123);
    fb = '{8'h00, 8'h10, 8'h0A, 8'hBC, 8'h01, 8'h23};
    send_frame();
    check("basic_accepts", n_acc - acc0, 32'd2);
    check("basic_valid_cycles", n_vcyc - vc0, 32'd2);

    // Address wrap; upper ADDR_HI bit must be ignored.
    push_exp(15'h7FFF, 12'hFFF);
    push_exp(15'h0000, 12'h102);
    fb = '{8'hFF, 8'hFF, 8'h0F, 8'hFF, 8'h01, 8'h02};
    send_frame();

    // Ready low for three pixels: only the first is held.
    bus.wr_ready = 1'b0;
    acc0 = n_acc;
    fb = '{8'h01, 8'h00, 8'h01, 8'h11, 8'h02, 8'h22, 8'h03, 8'h33};
    send_frame();
    check("stall_valid", {31'd0, bus.wr_valid}, 32'd1);
    check("stall_addr", {17'd0, bus.wr_addr}, 32'h0100);
    check("stall_data", {20'd0, bus.wr_data}, 32'h0111);
`ifdef SPI_RX_OVF_EN
    check("stall_overflow", {31'd0, overflow}, 32'd1);
`endif
    push_exp(15'h0100, 12'h111);
    @(negedge clk);
    bus.wr_ready = 1'b1;
    clk_wait(6);
    check("stall_accepts", n_acc - acc0, 32'd1);
    check("stall_valid_after", {31'd0, bus.wr_valid}, 32'd0);

    // Partial PIX_LO, then a fresh frame must re-decode its address.
    acc0 = n_acc;
    cs_start();
`ifdef SPI_RX_OVF_EN
    clk_wait(2);
    check("overflow_cleared", {31'd0, overflow}, 32'd0);
`endif
    fb = '{8'h00, 8'h20, 8'h0A};
    send_bytes();
    spi_bits(8'hFF, 5);
    cs_end();
    check("partial_no_write", n_acc - acc0, 32'd0);
    push_exp(15'h0030, 12'h456);
    fb = '{8'h00, 8'h30, 8'h04, 8'h56};
    send_frame();
    check("fresh_accepts", n_acc - acc0, 32'd1);

    // Reset with a pending write and a partial byte.
    bus.wr_ready = 1'b0;
    cs_start();
    fb = '{8'h00, 8'h40, 8'h07, 8'h89};
    send_bytes();
    spi_bits(8'hA5, 3);
    clk_wait(4);
    check("pre_reset_valid", {31'd0, bus.wr_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, bus.wr_valid}, 32'd0);
    check("rst_mid_addr", {17'd0, bus.wr_addr}, 32'd0);
    check("rst_mid_data", {20'd0, bus.wr_data}, 32'd0);
    clk_wait(3);
    reset = 1'b0;
    bus.wr_ready = 1'b1;
    acc0 = n_acc;
    // cs still low at release: this frame must be ignored.
    fb = '{8'h00, 8'h60, 8'h01, 8'h11};
    send_bytes();
    cs_end();
    check("cs_low_release_ignored", n_acc - acc0, 32'd0);
    push_exp(15'h0050, 12'hAAA);
    fb = '{8'h00, 8'h50, 8'h0A, 8'hAA};
    send_frame();
    check("post_reset_accepts", n_acc - acc0, 32'd1);

    // Accept of pixel 1 lands in the same cycle pixel 2 completes.
    bus.wr_ready = 1'b0;
    acc0 = n_acc;
    push_exp(15'h0200, 12'h123);
    push_exp(15'h0201, 12'h456);
    cs_start();
    fb = '{8'h02, 8'h00, 8'h01, 8'h23, 8'h04};
    send_bytes();
    fork
      spi_bits(8'h56, 8);
      begin
        repeat (8) @(posedge sck);
        repeat (3) @(posedge clk);
        #1 bus.wr_ready = 1'b1;
        @(posedge clk);
        #1 bus.wr_ready = 1'b0;
      end
    join
    cs_end();
    check("same_cycle_accepts", n_acc - acc0, 32'd1);
    check("same_cycle_valid", {31'd0, bus.wr_valid}, 32'd1);
`ifdef SPI_RX_OVF_EN
    check("same_cycle_overflow", {31'd0, overflow}, 32'd0);
`endif
    @(negedge clk);
    bus.wr_ready = 1'b1;
    clk_wait(4);
    check("same_cycle_total", n_acc - acc0, 32'd2);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
